wb_arbiter_2m: RTL
==================

# wb_arbiter_2m

Two-master Wishbone arbiter that shares one slave-side bus (memory/peripheral interconnect) between the 6502 bridge (master 0) and a second master such as a DMA engine or debug loader (master 1). Grants are per-transfer and round-robin on contention, so a master that keeps its strobe asserted continuously cannot starve the other. A per-transfer watchdog aborts transfers that are never acknowledged and reports them.

## Interface
- DATA_WIDTH, 8, data bus width
- ADDR_WIDTH, 16, address bus width
- TIMEOUT, 255, max cycles a granted transfer may wait for ack_i; 0 disables the watchdog
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-low reset
- m0_stb_i, m1_stb_i  in  1  master request strobes
- m0_we_i, m1_we_i  in  1  master write enables
- m0_adr_i, m1_adr_i  in  ADDR_WIDTH  master addresses
- m0_dat_i, m1_dat_i  in  DATA_WIDTH  master write data
- m0_ack_o, m1_ack_o  out  1  transfer acknowledge to master
- m0_err_o, m1_err_o  out  1  transfer aborted by watchdog (one-cycle pulse)
- m0_dat_o, m1_dat_o  out  DATA_WIDTH  read data to master (dat_i broadcast)
- stb_o  out  1  slave strobe
- we_o  out  1  slave write enable
- adr_o  out  ADDR_WIDTH  slave address
- dat_o  out  DATA_WIDTH  slave write data
- ack_i  in  1  slave acknowledge
- dat_i  in  DATA_WIDTH  slave read data
- busy_o  out  1  a transfer is granted
- grant_o  out  1  index of granted master (valid when busy_o)
- timeout_o  out  1  sticky: a watchdog abort has occurred since reset

## Operation
- States: IDLE, BUSY.
- IDLE: if neither strobe high, stay. If exactly one high, grant it. If both high, grant the master not equal to last_grant. Register grant, load last_grant, go BUSY.
- BUSY: stb_o = m[grant]_stb_i; we_o/adr_o/dat_o = granted master's inputs. m[grant]_ack_o = ack_i (combinational); non-granted ack/err = 0.
- BUSY exits to IDLE on: ack_i high; granted strobe dropped (abort, no ack/err); or watchdog expiry.
- Watchdog: counter cleared on entry to BUSY, increments each BUSY cycle without ack_i. When counter == TIMEOUT-1 and ack_i low: pulse m[grant]_err_o for that cycle, set timeout_o, go IDLE. ack_i and expiry in same cycle: ack wins, no err. TIMEOUT = 0: never expires.
- When not BUSY: stb_o, we_o, adr_o, dat_o all 0; ack_i ignored (stray ack not forwarded).
- m0_dat_o = m1_dat_o = dat_i always.
- Counter width = clog2(TIMEOUT+1), minimum 1; no wrap possible since expiry resets it.

## Timing
- Reset (rst_i low at a clock edge): state IDLE, last_grant = 1 (master 0 wins first tie), grant_o = 0, busy_o = 0, stb_o = 0, all ack/err = 0, counter = 0, timeout_o = 0. Reset mid-transfer drops stb_o the following cycle with no ack/err to the master.
- Request latency: strobe seen in IDLE at edge N -> stb_o high in cycle N+1.
- Zero-wait slave (ack_i same cycle as stb_o): transfer completes in that cycle; arbiter spends one IDLE cycle before next grant, so back-to-back throughput is one transfer per 2 cycles.
- Both masters requesting continuously: grants strictly alternate 0,1,0,1...
- Watchdog abort occurs exactly TIMEOUT cycles after stb_o rises.

## Test plan
- Reset: hold rst_i low 10 cycles with both strobes high -> stb_o=0, busy_o=0, timeout_o=0; release -> first grant_o=0, stb_o high one cycle later.
- Single master: m1 read adr 0x1234, slave acks after 3 cycles with dat_i=0xA5 -> adr_o=0x1234 for 3 cycles, m1_ack_o one pulse, m1_dat_o=0xA5, m0_ack_o stays 0.
- Contention: both strobes held high, zero-wait slave, 8 transfers -> grant sequence 0,1,0,1,0,1,0,1; each master gets 4 acks.
- Write passthrough: m0 writes 0x5A to 0xC000 -> we_o=1, adr_o=0xC000, dat_o=0x5A while granted; one m0_ack_o.
- Watchdog: TIMEOUT=4, slave never acks -> stb_o high exactly 4 cycles, m[grant]_err_o pulses once, timeout_o stays 1, other master then granted; ack_i on expiry cycle instead -> ack, no err.
- Abort/stray: granted master drops strobe before ack -> IDLE next cycle, no ack/err; ack_i pulsed while idle -> no master ack.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: per-transfer round-robin grant onto one slave bus,
// with a per-transfer watchdog that aborts unacknowledged transfers.
module wb_arbiter_2m #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  m0_stb_i,
   input  logic                  m1_stb_i,
   input  logic                  m0_we_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic                  m0_ack_o,
   output logic                  m1_ack_o,
   output logic                  m0_err_o,
   output logic                  m1_err_o,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   output logic                  stb_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic                  ack_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic                  busy_o,
   output logic                  grant_o,
   output logic                  timeout_o
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            to_q, to_d;
   logic            busy, g_stb, expire;

   assign busy  = (state_q == BUSY);
   assign g_stb = grant_q ? m1_stb_i : m0_stb_i;
   // Expiry only counts while the granted master still wants the transfer; ack wins a tie.
   assign expire = (TIMEOUT != 0) && busy && g_stb && !ack_i && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      to_d    = to_q | expire;
      case (state_q)
         IDLE: begin
            if (m0_stb_i || m1_stb_i) begin
               // On contention master 1 wins only if master 0 had the last grant.
               grant_d = m1_stb_i && (!m0_stb_i || !last_q);
               last_d  = grant_d;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (ack_i || !g_stb || expire) state_d = IDLE;
            else                           cnt_d   = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign stb_o     = busy && g_stb;
   assign we_o      = busy && (grant_q ? m1_we_i : m0_we_i);
   assign adr_o     = busy ? (grant_q ? m1_adr_i : m0_adr_i) : '0;
   assign dat_o     = busy ? (grant_q ? m1_dat_i : m0_dat_i) : '0;
   assign m0_ack_o  = busy && !grant_q && ack_i;
   assign m1_ack_o  = busy &&  grant_q && ack_i;
   assign m0_err_o  = expire && !grant_q;
   assign m1_err_o  = expire &&  grant_q;
   assign m0_dat_o  = dat_i;
   assign m1_dat_o  = dat_i;
   assign busy_o    = busy;
   assign grant_o   = grant_q;
   assign timeout_o = to_q;

endmodule
